// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: bundle between the 5-stage datapath and its hazard unit.
//  master : the datapath - drives the ID-stage decode fields and flush_req,
//           consumes stall/bubble/flush, the forwarding selects, the ID bypasses
//           and the event counters.
//  slave  : the hazard unit - the reverse direction of every signal.
//  AW     : register-file address width.
//  STAT_W : width of the stall/flush event counters.
interface pipe_hazard_if #(
    parameter int AW     = 5,
    parameter int STAT_W = 16
);
    logic              id_valid;
    logic [AW-1:0]     id_rs;
    logic [AW-1:0]     id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [AW-1:0]     id_wr_addr;
    logic              id_is_load;
    logic              flush_req;
    logic              stall;
    logic              bubble_ex;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              id_byp_a;
    logic              id_byp_b;
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, flush_req,
        input  stall, bubble_ex, flush, fwd_a, fwd_b,
               id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, flush_req,
        output stall, bubble_ex, flush, fwd_a, fwd_b,
               id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard and forwarding controller for an IF/ID/EX/MEM/WB
// pipeline. Keeps a shadow of destination/load info for EX, MEM and WB and from
// it produces load-use stalls, branch flushes, EX operand forwarding selects and
// the ID-stage same-cycle WB bypass.
//  clk   : pipeline clock
//  rst_n : asynchronous active-low reset
//  hz    : pipe_hazard_if slave (ID decode fields and flush_req in; stall,
//          bubble_ex, flush, fwd_a/b, id_byp_a/b, stall_cnt, flush_cnt out)
// Parameters: AW address width, STAT_W counter width (>= 2), FWD_EN enables
// forwarding (0: stall on any RAW against EX or MEM), ZERO_REG makes r0 a
// never-hazard register.
module pipe_hazard_unit #(
    parameter int AW       = 5,
    parameter int STAT_W   = 16,
    parameter int FWD_EN   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave hz
);
    localparam logic              FWD_ON    = (FWD_EN != 0);
    localparam logic [AW-1:0]     ZERO_ADDR = {AW{1'b0}};
    localparam logic [STAT_W-1:0] CNT_MAX   = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] CNT_ONE   = {{(STAT_W-1){1'b0}}, 1'b1};

    // Shadow state. WB keeps no load flag: nothing downstream of WB cares.
    logic          ex_v_r, ex_we_r, ex_ld_r, ex_urs_r, ex_urt_r;
    logic [AW-1:0] ex_wa_r, ex_rs_r, ex_rt_r;
    logic          mem_v_r, mem_we_r, mem_ld_r;
    logic [AW-1:0] mem_wa_r;
    logic          wb_v_r, wb_we_r;
    logic [AW-1:0] wb_wa_r;
    logic [STAT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic       rd_rs_s, rd_rt_s;
    logic       ex_hit_rs_s, ex_hit_rt_s, mem_hit_rs_s, mem_hit_rt_s;
    logic       mem_hit_exrs_s, mem_hit_exrt_s, wb_hit_exrs_s, wb_hit_exrt_s;
    logic       raw_s, stall_s, flush_s, load_ex_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       byp_a_s, byp_b_s;

    // A stage holds a live write to register r that is not the hardwired zero.
    function automatic logic match_f(input logic v, input logic we,
                                     input logic [AW-1:0] wa, input logic [AW-1:0] r);
        logic zero_hit;
        zero_hit = (ZERO_REG != 0) && (r == ZERO_ADDR);
        return v & we & (wa == r) & ~zero_hit;
    endfunction

    // Hazard detection: stall/flush decision for the instruction sitting in ID.
    always_comb begin
        rd_rs_s      = hz.id_valid & hz.id_use_rs;
        rd_rt_s      = hz.id_valid & hz.id_use_rt;
        ex_hit_rs_s  = match_f(ex_v_r, ex_we_r, ex_wa_r, hz.id_rs);
        ex_hit_rt_s  = match_f(ex_v_r, ex_we_r, ex_wa_r, hz.id_rt);
        mem_hit_rs_s = match_f(mem_v_r, mem_we_r, mem_wa_r, hz.id_rs);
        mem_hit_rt_s = match_f(mem_v_r, mem_we_r, mem_wa_r, hz.id_rt);
        raw_s        = 1'b0;
        if (FWD_ON) begin
            // Only a load in EX cannot be forwarded in time.
            raw_s = ex_ld_r & ((rd_rs_s & ex_hit_rs_s) | (rd_rt_s & ex_hit_rt_s));
        end else begin
            // WB is covered by the ID bypass; EX and MEM must drain first.
            raw_s = (rd_rs_s & (ex_hit_rs_s | mem_hit_rs_s)) |
                    (rd_rt_s & (ex_hit_rt_s | mem_hit_rt_s));
        end
        flush_s   = hz.flush_req;
        // Flush wins: the stalled instruction is being killed anyway.
        stall_s   = raw_s & ~flush_s;
        load_ex_s = hz.id_valid & ~stall_s & ~flush_s;
    end

    // Forwarding selects for the EX operands plus the ID-stage WB bypass.
    always_comb begin
        mem_hit_exrs_s = match_f(mem_v_r, mem_we_r, mem_wa_r, ex_rs_r);
        mem_hit_exrt_s = match_f(mem_v_r, mem_we_r, mem_wa_r, ex_rt_r);
        wb_hit_exrs_s  = match_f(wb_v_r, wb_we_r, wb_wa_r, ex_rs_r);
        wb_hit_exrt_s  = match_f(wb_v_r, wb_we_r, wb_wa_r, ex_rt_r);
        fwd_a_s        = 2'b00;
        fwd_b_s        = 2'b00;
        // The younger MEM result beats WB; a load in MEM has no result yet.
        if (FWD_ON && ex_urs_r && mem_hit_exrs_s && !mem_ld_r) begin
            fwd_a_s = 2'b01;
        end else if (FWD_ON && ex_urs_r && wb_hit_exrs_s) begin
            fwd_a_s = 2'b10;
        end else begin
            fwd_a_s = 2'b00;
        end
        if (FWD_ON && ex_urt_r && mem_hit_exrt_s && !mem_ld_r) begin
            fwd_b_s = 2'b01;
        end else if (FWD_ON && ex_urt_r && wb_hit_exrt_s) begin
            fwd_b_s = 2'b10;
        end else begin
            fwd_b_s = 2'b00;
        end
        byp_a_s = rd_rs_s & match_f(wb_v_r, wb_we_r, wb_wa_r, hz.id_rs);
        byp_b_s = rd_rt_s & match_f(wb_v_r, wb_we_r, wb_wa_r, hz.id_rt);
    end

    assign hz.stall     = stall_s;
    assign hz.bubble_ex = stall_s | flush_s;
    assign hz.flush     = flush_s;
    assign hz.fwd_a     = fwd_a_s;
    assign hz.fwd_b     = fwd_b_s;
    assign hz.id_byp_a  = byp_a_s;
    assign hz.id_byp_b  = byp_b_s;
    assign hz.stall_cnt = stall_cnt_r;
    assign hz.flush_cnt = flush_cnt_r;

    // Shadow pipeline: MEM/WB always advance, EX takes ID or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_r  <= 1'b0;  ex_we_r <= 1'b0;  ex_ld_r <= 1'b0;
            ex_urs_r <= 1'b0; ex_urt_r <= 1'b0;
            ex_wa_r <= ZERO_ADDR; ex_rs_r <= ZERO_ADDR; ex_rt_r <= ZERO_ADDR;
            mem_v_r <= 1'b0; mem_we_r <= 1'b0; mem_ld_r <= 1'b0; mem_wa_r <= ZERO_ADDR;
            wb_v_r  <= 1'b0; wb_we_r  <= 1'b0; wb_wa_r  <= ZERO_ADDR;
        end else begin
            wb_v_r  <= mem_v_r;
            wb_we_r <= mem_we_r;
            wb_wa_r <= mem_wa_r;
            if (flush_s) begin
                // The instruction in EX is younger than the branch in MEM.
                mem_v_r  <= 1'b0;
                mem_we_r <= 1'b0;
                mem_ld_r <= 1'b0;
                mem_wa_r <= ZERO_ADDR;
            end else begin
                mem_v_r  <= ex_v_r;
                mem_we_r <= ex_we_r;
                mem_ld_r <= ex_ld_r;
                mem_wa_r <= ex_wa_r;
            end
            if (load_ex_s) begin
                ex_v_r   <= 1'b1;
                ex_we_r  <= hz.id_wr_en;
                ex_ld_r  <= hz.id_is_load;
                ex_wa_r  <= hz.id_wr_addr;
                ex_rs_r  <= hz.id_rs;
                ex_rt_r  <= hz.id_rt;
                ex_urs_r <= hz.id_use_rs;
                ex_urt_r <= hz.id_use_rt;
            end else begin
                ex_v_r   <= 1'b0;
                ex_we_r  <= 1'b0;
                ex_ld_r  <= 1'b0;
                ex_wa_r  <= ZERO_ADDR;
                ex_rs_r  <= ZERO_ADDR;
                ex_rt_r  <= ZERO_ADDR;
                ex_urs_r <= 1'b0;
                ex_urt_r <= 1'b0;
            end
        end
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STAT_W{1'b0}};
            flush_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: three configurations of pipe_hazard_unit share one
// stimulus stream: 0 = defaults, 1 = ZERO_REG=0, 2 = FWD_EN=0/STAT_W=2.
// Each is compared every cycle with an instruction-level pipeline model.
module tb_pipe_hazard_unit;
    logic clk;
    logic rst_n;
    logic t_valid, t_urs, t_urt, t_we, t_ld, t_fr;
    logic [4:0] t_rs, t_rt, t_wa;

    pipe_hazard_if #(.AW(5), .STAT_W(16)) ifa ();
    pipe_hazard_if #(.AW(5), .STAT_W(16)) ifz ();
    pipe_hazard_if #(.AW(5), .STAT_W(2))  ifn ();

    assign ifa.id_valid = t_valid; assign ifz.id_valid = t_valid; assign ifn.id_valid = t_valid;
    assign ifa.id_rs = t_rs;       assign ifz.id_rs = t_rs;       assign ifn.id_rs = t_rs;
    assign ifa.id_rt = t_rt;       assign ifz.id_rt = t_rt;       assign ifn.id_rt = t_rt;
    assign ifa.id_use_rs = t_urs;  assign ifz.id_use_rs = t_urs;  assign ifn.id_use_rs = t_urs;
    assign ifa.id_use_rt = t_urt;  assign ifz.id_use_rt = t_urt;  assign ifn.id_use_rt = t_urt;
    assign ifa.id_wr_en = t_we;    assign ifz.id_wr_en = t_we;    assign ifn.id_wr_en = t_we;
    assign ifa.id_wr_addr = t_wa;  assign ifz.id_wr_addr = t_wa;  assign ifn.id_wr_addr = t_wa;
    assign ifa.id_is_load = t_ld;  assign ifz.id_is_load = t_ld;  assign ifn.id_is_load = t_ld;
    assign ifa.flush_req = t_fr;   assign ifz.flush_req = t_fr;   assign ifn.flush_req = t_fr;

    pipe_hazard_unit #(.AW(5), .STAT_W(16), .FWD_EN(1), .ZERO_REG(1)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    pipe_hazard_unit #(.AW(5), .STAT_W(16), .FWD_EN(1), .ZERO_REG(0)) dut_z (.clk(clk), .rst_n(rst_n), .hz(ifz));
    pipe_hazard_unit #(.AW(5), .STAT_W(2),  .FWD_EN(0), .ZERO_REG(1)) dut_n (.clk(clk), .rst_n(rst_n), .hz(ifn));

    logic o_stall [3], o_bub [3], o_flush [3], o_ba [3], o_bb [3];
    logic [1:0]  o_fa [3], o_fb [3];
    logic [15:0] o_sc [3], o_fc [3];
    assign o_stall[0] = ifa.stall; assign o_stall[1] = ifz.stall; assign o_stall[2] = ifn.stall;
    assign o_bub[0] = ifa.bubble_ex; assign o_bub[1] = ifz.bubble_ex; assign o_bub[2] = ifn.bubble_ex;
    assign o_flush[0] = ifa.flush; assign o_flush[1] = ifz.flush; assign o_flush[2] = ifn.flush;
    assign o_fa[0] = ifa.fwd_a; assign o_fa[1] = ifz.fwd_a; assign o_fa[2] = ifn.fwd_a;
    assign o_fb[0] = ifa.fwd_b; assign o_fb[1] = ifz.fwd_b; assign o_fb[2] = ifn.fwd_b;
    assign o_ba[0] = ifa.id_byp_a; assign o_ba[1] = ifz.id_byp_a; assign o_ba[2] = ifn.id_byp_a;
    assign o_bb[0] = ifa.id_byp_b; assign o_bb[1] = ifz.id_byp_b; assign o_bb[2] = ifn.id_byp_b;
    assign o_sc[0] = ifa.stall_cnt; assign o_sc[1] = ifz.stall_cnt; assign o_sc[2] = {14'd0, ifn.stall_cnt};
    assign o_fc[0] = ifa.flush_cnt; assign o_fc[1] = ifz.flush_cnt; assign o_fc[2] = {14'd0, ifn.flush_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one record per in-flight instruction
    typedef struct {
        bit v, we, ld, urs, urt;
        int wa, rs, rt;
    } ins_t;
    ins_t pipe [3][3];           // [config][0=EX,1=MEM,2=WB]
    int   scnt [3], fcnt [3];
    bit   cfg_fwd [3] = '{1'b1, 1'b1, 1'b0};
    bit   cfg_zr  [3] = '{1'b1, 1'b0, 1'b1};
    int   cfg_max [3] = '{65535, 65535, 3};

    function automatic ins_t empty_ins();
        ins_t e;
        e = '{v: 1'b0, we: 1'b0, ld: 1'b0, urs: 1'b0, urt: 1'b0, wa: 0, rs: 0, rt: 0};
        return e;
    endfunction

    function automatic bit produces(int d, int k, int r);
        if (cfg_zr[d] && r == 0) return 1'b0;
        return pipe[d][k].v && pipe[d][k].we && pipe[d][k].wa == r;
    endfunction

    function automatic int src_sel(int d, bit used, int r);
        if (!cfg_fwd[d] || !used) return 0;
        if (produces(d, 1, r) && !pipe[d][1].ld) return 1;
        if (produces(d, 2, r)) return 2;
        return 0;
    endfunction

    function automatic void model_out(input int d, output bit st, output bit fl,
                                      output int fa, output int fb, output bit ba, output bit bb);
        bit ra, rb, hz;
        ra = t_valid && t_urs;
        rb = t_valid && t_urt;
        if (cfg_fwd[d])
            hz = pipe[d][0].ld && ((ra && produces(d, 0, int'(t_rs))) || (rb && produces(d, 0, int'(t_rt))));
        else
            hz = (ra && (produces(d, 0, int'(t_rs)) || produces(d, 1, int'(t_rs)))) ||
                 (rb && (produces(d, 0, int'(t_rt)) || produces(d, 1, int'(t_rt))));
        fl = t_fr;
        st = hz && !fl;
        fa = src_sel(d, pipe[d][0].urs, pipe[d][0].rs);
        fb = src_sel(d, pipe[d][0].urt, pipe[d][0].rt);
        ba = ra && produces(d, 2, int'(t_rs));
        bb = rb && produces(d, 2, int'(t_rt));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 3; k++) pipe[d][k] = empty_ins();
            scnt[d] = 0;
            fcnt[d] = 0;
        end
    endtask

    task automatic model_advance();
        bit st, fl, ba, bb;
        int fa, fb;
        ins_t nx;
        for (int d = 0; d < 3; d++) begin
            model_out(d, st, fl, fa, fb, ba, bb);
            nx = empty_ins();
            if (t_valid && !st && !fl)
                nx = '{v: 1'b1, we: t_we, ld: t_ld, urs: t_urs, urt: t_urt,
                       wa: int'(t_wa), rs: int'(t_rs), rt: int'(t_rt)};
            pipe[d][2] = pipe[d][1];
            pipe[d][1] = fl ? empty_ins() : pipe[d][0];
            pipe[d][0] = nx;
            if (st && scnt[d] < cfg_max[d]) scnt[d]++;
            if (fl && fcnt[d] < cfg_max[d]) fcnt[d]++;
        end
    endtask

    task automatic check_models();
        bit st, fl, ba, bb;
        int fa, fb;
        for (int d = 0; d < 3; d++) begin
            model_out(d, st, fl, fa, fb, ba, bb);
            chk("stall", d, {31'd0, o_stall[d]}, {31'd0, st});
            chk("bubble_ex", d, {31'd0, o_bub[d]}, {31'd0, st | fl});
            chk("flush", d, {31'd0, o_flush[d]}, {31'd0, fl});
            chk("fwd_a", d, {30'd0, o_fa[d]}, fa);
            chk("fwd_b", d, {30'd0, o_fb[d]}, fb);
            chk("id_byp_a", d, {31'd0, o_ba[d]}, {31'd0, ba});
            chk("id_byp_b", d, {31'd0, o_bb[d]}, {31'd0, bb});
            chk("stall_cnt", d, {16'd0, o_sc[d]}, scnt[d]);
            chk("flush_cnt", d, {16'd0, o_fc[d]}, fcnt[d]);
        end
    endtask

    // Caller stands just after a posedge; outputs are sampled on the negedge.
    task automatic sample();
        @(negedge clk);
        check_models();
    endtask

    task automatic advance(input bit run_model);
        if (run_model) model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit we, input int wa, input bit ld, input bit fr);
        t_valid = v; t_rs = rs[4:0]; t_rt = rt[4:0]; t_urs = urs; t_urt = urt;
        t_we = we; t_wa = wa[4:0]; t_ld = ld; t_fr = fr;
    endtask

    task automatic drive_random(input bit allow_flush, input int amax);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, amax), $urandom_range(0, amax),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
              $urandom_range(0, amax), $urandom_range(0, 2) == 0,
              allow_flush && ($urandom_range(0, 7) == 0));
    endtask

    // Async reset from mid-cycle, checked at once and over 3 clocks.
    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_models();
        for (int i = 0; i < 3; i++) begin
            drive_random(1'b0, 7);
            sample();
            advance(1'b0);
        end
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table (config 0 expectations, plus config 1 fwd)
    typedef struct {
        bit v; int rs, rt; bit urs, urt, we; int wa; bit ld, fr;
        bit e_st, e_fl; int e_fa, e_fb; bit e_ba, e_bb; int z_fa, z_fb;
    } vec_t;
    vec_t tbl [13];

    function automatic vec_t mkv(bit v, int rs, int rt, bit urs, bit urt, bit we, int wa, bit ld, bit fr,
                                 bit est, bit efl, int efa, int efb, bit eba, bit ebb, int zfa, int zfb);
        vec_t r;
        r = '{v: v, rs: rs, rt: rt, urs: urs, urt: urt, we: we, wa: wa, ld: ld, fr: fr,
              e_st: est, e_fl: efl, e_fa: efa, e_fb: efb, e_ba: eba, e_bb: ebb, z_fa: zfa, z_fb: zfb};
        return r;
    endfunction

    int exp_stall [8];

    initial begin
        //                  v rs rt us ut we wa ld fr | st fl fa fb ba bb zfa zfb
        tbl[0]  = mkv(1, 1, 0, 1, 0, 1, 5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0); // LW r5
        tbl[1]  = mkv(1, 5, 2, 1, 1, 1, 6, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0); // ADD reads r5: load-use
        tbl[2]  = mkv(1, 5, 2, 1, 1, 1, 6, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // held ADD proceeds
        tbl[3]  = mkv(1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 2, 0, 0, 0, 2, 0); // SUB r3; ADD gets WB load
        tbl[4]  = mkv(1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // ADD r3
        tbl[5]  = mkv(1, 3, 3, 1, 1, 1, 8, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // reader of r3
        tbl[6]  = mkv(1, 3, 3, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 1, 1); // MEM beats WB; ID bypass
        tbl[7]  = mkv(1, 1, 0, 1, 0, 1, 9, 1, 0,  0, 0, 2, 0, 0, 0, 2, 0); // only WB writer left; LW r9
        tbl[8]  = mkv(1, 9, 0, 1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0); // load-use + flush
        tbl[9]  = mkv(1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // writer of r0
        tbl[10] = mkv(1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // writer of r0
        tbl[11] = mkv(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0); // reader of r0
        tbl[12] = mkv(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1); // r0 never forwarded
        exp_stall = '{0, 1, 1, 0, 0, 1, 1, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        apply_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].we,
                  tbl[i].wa, tbl[i].ld, tbl[i].fr);
            sample();
            chk($sformatf("tbl%0d_stall", i), 0, {31'd0, ifa.stall}, {31'd0, tbl[i].e_st});
            chk($sformatf("tbl%0d_bubble", i), 0, {31'd0, ifa.bubble_ex}, {31'd0, tbl[i].e_st | tbl[i].e_fl});
            chk($sformatf("tbl%0d_flush", i), 0, {31'd0, ifa.flush}, {31'd0, tbl[i].e_fl});
            chk($sformatf("tbl%0d_fwd_a", i), 0, {30'd0, ifa.fwd_a}, tbl[i].e_fa);
            chk($sformatf("tbl%0d_fwd_b", i), 0, {30'd0, ifa.fwd_b}, tbl[i].e_fb);
            chk($sformatf("tbl%0d_byp_a", i), 0, {31'd0, ifa.id_byp_a}, {31'd0, tbl[i].e_ba});
            chk($sformatf("tbl%0d_byp_b", i), 0, {31'd0, ifa.id_byp_b}, {31'd0, tbl[i].e_bb});
            chk($sformatf("tbl%0d_zfwd_a", i), 1, {30'd0, ifz.fwd_a}, tbl[i].z_fa);
            chk($sformatf("tbl%0d_zfwd_b", i), 1, {30'd0, ifz.fwd_b}, tbl[i].z_fb);
            if (i == 3) chk("load_use_stall_cnt", 0, {16'd0, ifa.stall_cnt}, 32'd1);
            if (i == 9) chk("flush_cnt_after_flush", 0, {16'd0, ifa.flush_cnt}, 32'd1);
            advance(1'b1);
        end

        // No forwarding: back-to-back RAW on r7 twice, stall counter saturates.
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 4) drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
            else                  drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
            sample();
            chk($sformatf("nofwd_stall_c%0d", c), 2, {31'd0, ifn.stall}, exp_stall[c]);
            if (c == 3) chk("nofwd_stall_cnt_mid", 2, {30'd0, ifn.stall_cnt}, 32'd2);
            if (c == 7) chk("nofwd_stall_cnt_sat", 2, {30'd0, ifn.stall_cnt}, 32'd3);
            advance(1'b1);
        end

        // Random traffic on a small register window, with a mid-run reset.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) apply_reset();
            drive_random(1'b1, 3);
            sample();
            advance(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
